shift_seq: RTL and testbench
============================

# shift_seq

Multi-cycle shift/rotate sequencer paired with the combinational bitwise ALU slice. It accepts one operand plus a shift amount and shifts one bit position per clock through a carry bit. It reports completion with a one-cycle `done` pulse. Final carry is delivered on `cout` in the same form as the ALU carry chain, so the result can be fed straight back as `cin` to the next ALU operation.

## Interface
- `WIDTH`, 8: operand width in bits.
- `AMT_W`, 3: shift-amount width; must satisfy 2^AMT_W ≥ WIDTH.
- `clk`  input  1: sole clock, rising edge.
- `rst_n`  input  1: asynchronous active-low reset.
- `start`  input  1: request; sampled only when `busy`=0.
- `op`  input  2: 00 SHL, 01 ROL-through-carry, 10 SHR logical, 11 ASR.
- `amount`  input  AMT_W: number of single-bit steps, 0..2^AMT_W−1.
- `a`  input  WIDTH: operand, captured at start.
- `cin`  input  1: initial carry, captured at start.
- `busy`  output  1: high while steps are in progress.
- `done`  output  1: one-cycle completion pulse.
- `q`  output  WIDTH: result register.
- `cout`  output  1: carry register.

## Operation
- The block has three states: IDLE, SHIFT and DONE. `busy` = (state==SHIFT). `done` = (state==DONE).
- **Accepting a request:** when `start`=1 in IDLE or DONE, the block loads `q`←`a`, `cout`←`cin`, `op_r`←`op`, `cnt`←`amount`.
  - Next state is SHIFT if `amount`≠0, otherwise DONE.
- **SHIFT:** each clock performs exactly one step and then decrements `cnt`. When the step that brings `cnt` to 0 completes, the state goes to DONE.
- **DONE:** lasts one cycle, then returns to IDLE unless a new `start` is accepted.
- **Step rules** (with `WIDTH`=8):
  - SHL: `cout`←q[7], `q`←{q[6:0],0}.
  - ROL: `cout`←q[7], `q`←{q[6:0],cout}. This is a 9-bit rotate.
  - SHR: `cout`←q[0], `q`←{0,q[7:1]}.
  - ASR: `cout`←q[0], `q`←{q[7],q[7:1]}.
- `amount`=0 yields `q`=`a` and `cout`=`cin`.
- `q` and `cout` hold their last values until the next accepted `start`. They are valid whenever `busy`=0.
- `start` while `busy`=1 is ignored. It is not queued, and `op`, `amount`, `a` and `cin` are not sampled.
- `op`, `amount`, `a` and `cin` may change freely after the accepting edge.

## Timing
- **Reset:** asserting `rst_n` low forces state=IDLE, `cnt`=0, `q`=0, `cout`=0, `busy`=0, `done`=0, immediately and independently of `clk`.
  - Reset mid-SHIFT aborts the operation with no `done` pulse.
  - After release, the first rising edge with `start`=1 is accepted.
- **Latency:** with the accepting edge counted as edge 0 and N=`amount`:
  - `busy` is high for edges 1..N.
  - `done` is high for the cycle after edge N.
  - Total start-to-done latency is N+1 edges; N=0 gives `done` right after edge 0.
- **Back-to-back:** a `start` during the DONE cycle is accepted. The next operation therefore begins with no idle gap.

## Configuration
- `SHIFT_SEQ_ZFLAG_EN` defined:
  - Adds output port `z` (1 bit), registered and set to (`q`==0) alongside every update of `q`.
  - `z` resets to 1, consistent with `q`=0.
- `SHIFT_SEQ_ZFLAG_EN` undefined: port `z` and its logic do not exist. All other behaviour is identical.

## Test plan
- **SHL:** `op`=00, `a`=0x81, `cin`=0, `amount`=1 → `busy` high for 1 cycle, then `done` pulse; `q`=0x02, `cout`=1.
- **ROL:** `op`=01, `a`=0x80, `cin`=0, `amount`=2 → after step 1, `q`=0x00 and `cout`=1; at `done`, `q`=0x01 and `cout`=0, 3 edges after start.
- **ASR:** `op`=11, `a`=0x90, `amount`=3 → `q`=0xF2, `cout`=0; `done` high exactly once, in the cycle after edge 3.
- **Zero amount:** `op`=10, `a`=0x5A, `cin`=1, `amount`=0 → `done` in the cycle after the start edge, `busy` never high, `q`=0x5A, `cout`=1.
- **Busy and back-to-back:** start SHR with `a`=0xFF, `amount`=7, and pulse `rst_n` low at edge 3 → all outputs reach reset values asynchronously and no `done` occurs. Then:
  - A `start` with `amount`=5 while `busy` is ignored.
  - A `start` in the DONE cycle of the previous operation begins its first step on the next edge.
- **Zero flag** (`SHIFT_SEQ_ZFLAG_EN` defined): `op`=10, `a`=0x01, `amount`=1 → `q`=0x00, `cout`=1, `z`=1. Then SHL with `a`=0x40, `amount`=1 → `z`=0.

Source files
------------

// File: rtl/shift_seq.sv
// rtl/shift_seq.sv - one-bit-per-clock shift/rotate sequencer with carry.
// Optional registered zero flag output z_o when SHIFT_SEQ_ZFLAG_EN is defined.
module shift_seq #(
  parameter int WIDTH = 8,
  parameter int AMT_W = 3
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [AMT_W-1:0] amount_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic             cin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] q_o,
`ifdef SHIFT_SEQ_ZFLAG_EN
  output logic             z_o,
`endif
  output logic             cout_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SHL = 2'b00;
  localparam logic [1:0] OP_ROL = 2'b01;
  localparam logic [1:0] OP_SHR = 2'b10;
  localparam logic [1:0] OP_ASR = 2'b11;

  state_t           state_q, state_d;
  logic [AMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             cout_q, cout_d;
  logic [1:0]       op_q, op_d;
  logic             accept;

  // Requests are taken in IDLE and in DONE, which gives back-to-back operation.
  assign accept = start_i && (state_q != ST_SHIFT);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      q_q     <= '0;
      cout_q  <= 1'b0;
      op_q    <= OP_SHL;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      cout_q  <= cout_d;
      op_q    <= op_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          state_d = (amount_i != '0) ? ST_SHIFT : ST_DONE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (cnt_q == AMT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    q_d    = q_q;
    cout_d = cout_q;
    op_d   = op_q;
    if (accept) begin
      cnt_d  = amount_i;
      q_d    = a_i;
      cout_d = cin_i;
      op_d   = op_i;
    end else if (state_q == ST_SHIFT) begin
      cnt_d = cnt_q - AMT_W'(1);
      case (op_q)
        OP_SHL: begin
          cout_d = q_q[WIDTH-1];
          q_d    = {q_q[WIDTH-2:0], 1'b0};
        end
        OP_ROL: begin
          cout_d = q_q[WIDTH-1];
          q_d    = {q_q[WIDTH-2:0], cout_q};
        end
        OP_SHR: begin
          cout_d = q_q[0];
          q_d    = {1'b0, q_q[WIDTH-1:1]};
        end
        default: begin
          cout_d = q_q[0];
          q_d    = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
        end
      endcase
    end
  end

  always_comb begin
    busy_o = (state_q == ST_SHIFT);
    done_o = (state_q == ST_DONE);
    q_o    = q_q;
    cout_o = cout_q;
  end

`ifdef SHIFT_SEQ_ZFLAG_EN
  logic z_q;

  // Tracks q through every load and step so it is valid alongside q.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      z_q <= 1'b1;
    end else if (accept || (state_q == ST_SHIFT)) begin
      z_q <= (q_d == '0);
    end
  end

  assign z_o = z_q;
`endif

endmodule

// File: tb/tb_shift_seq.sv
// tb/tb_shift_seq.sv - directed table-driven bench for shift_seq.
// Zero flag checks compile in when SHIFT_SEQ_ZFLAG_EN is defined.
module tb_shift_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] op;
  logic [2:0] amount;
  logic [7:0] a;
  logic       cin;
  logic       busy, done, cout;
  logic [7:0] q;
`ifdef SHIFT_SEQ_ZFLAG_EN
  logic       z;
`endif

  always #5 clk = ~clk;

  shift_seq #(.WIDTH(8), .AMT_W(3)) dut (
    .clk_i    (clk),
    .rst_n_i  (rst_n),
    .start_i  (start),
    .op_i     (op),
    .amount_i (amount),
    .a_i      (a),
    .cin_i    (cin),
    .busy_o   (busy),
    .done_o   (done),
    .q_o      (q),
`ifdef SHIFT_SEQ_ZFLAG_EN
    .z_o      (z),
`endif
    .cout_o   (cout)
  );

  typedef struct {
    logic [1:0] op;
    logic [2:0] amt;
    logic [7:0] a;
    logic       cin;
    logic [7:0] exp_q;
    logic       exp_cout;
  } vec_t;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Presents a request on a falling edge; returns 1 ns after the accepting edge.
  task automatic drive_start(input logic [1:0] o, input logic [2:0] n,
                             input logic [7:0] av, input logic c);
    @(negedge clk);
    start  = 1'b1;
    op     = o;
    amount = n;
    a      = av;
    cin    = c;
    @(posedge clk);
    #1;
    start  = 1'b0;
    op     = ~o;
    a      = ~av;
    cin    = ~c;
  endtask

  // k counts edges after the accepting edge; done must show at k == amount.
  task automatic wait_done(output int lat, output int bcnt);
    lat  = -1;
    bcnt = 0;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (busy) bcnt++;
      @(negedge clk);
    end
  endtask

  vec_t vecs[10];
  int   lat, bcnt, dcnt;

  initial begin
    vecs[0] = '{2'b00, 3'd1, 8'h81, 1'b0, 8'h02, 1'b1};
    vecs[1] = '{2'b01, 3'd2, 8'h80, 1'b0, 8'h01, 1'b0};
    vecs[2] = '{2'b11, 3'd3, 8'h90, 1'b0, 8'hF2, 1'b0};
    vecs[3] = '{2'b10, 3'd0, 8'h5A, 1'b1, 8'h5A, 1'b1};
    vecs[4] = '{2'b10, 3'd7, 8'hFF, 1'b0, 8'h01, 1'b1};
    vecs[5] = '{2'b01, 3'd1, 8'h55, 1'b1, 8'hAB, 1'b0};
    vecs[6] = '{2'b00, 3'd7, 8'h01, 1'b0, 8'h80, 1'b0};
    vecs[7] = '{2'b01, 3'd7, 8'h00, 1'b1, 8'h40, 1'b0};
    vecs[8] = '{2'b11, 3'd7, 8'h7F, 1'b0, 8'h00, 1'b1};
    vecs[9] = '{2'b10, 3'd7, 8'h80, 1'b1, 8'h01, 1'b0};

    rst_n = 1'b0; start = 1'b0; op = 2'b00; amount = '0; a = '0; cin = 1'b0;
    #3;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q", q, 0);
    check("rst_cout", cout, 0);
`ifdef SHIFT_SEQ_ZFLAG_EN
    check("rst_z", z, 1);
`endif
    #20;
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      drive_start(vecs[i].op, vecs[i].amt, vecs[i].a, vecs[i].cin);
      wait_done(lat, bcnt);
      check($sformatf("v%0d_latency", i), lat, vecs[i].amt);
      check($sformatf("v%0d_busy_cycles", i), bcnt, vecs[i].amt);
      check($sformatf("v%0d_q", i), q, vecs[i].exp_q);
      check($sformatf("v%0d_cout", i), cout, vecs[i].exp_cout);
      @(negedge clk);
      check($sformatf("v%0d_done_once", i), done, 0);
      check($sformatf("v%0d_idle", i), busy, 0);
      check($sformatf("v%0d_q_hold", i), q, vecs[i].exp_q);
    end

    // ROL intermediate step through the carry bit
    drive_start(2'b01, 3'd2, 8'h80, 1'b0);
    @(negedge clk);
    check("rol_k0_busy", busy, 1);
    @(negedge clk);
    check("rol_step1_q", q, 8'h00);
    check("rol_step1_cout", cout, 1);
    @(negedge clk);
    check("rol_done", done, 1);
    check("rol_final_q", q, 8'h01);
    check("rol_final_cout", cout, 0);

    // Asynchronous reset in the middle of a shift
    drive_start(2'b10, 3'd7, 8'hFF, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_q", q, 0);
    check("arst_cout", cout, 0);
`ifdef SHIFT_SEQ_ZFLAG_EN
    check("arst_z", z, 1);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    dcnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("arst_no_done", dcnt, 0);
    check("arst_idle", busy, 0);

    // Start while busy must be ignored
    drive_start(2'b10, 3'd7, 8'hFF, 1'b0);
    lat = -1;
    @(negedge clk);
    for (int k = 0; k < 40; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      start = (k >= 1 && k <= 2);
      if (start) begin
        op = 2'b00; amount = 3'd5; a = 8'h00; cin = 1'b1;
      end
      @(negedge clk);
    end
    start = 1'b0;
    check("ign_latency", lat, 7);
    check("ign_q", q, 8'h01);
    check("ign_cout", cout, 1);

    // Back-to-back: new request accepted during DONE
    drive_start(2'b00, 3'd1, 8'h03, 1'b0);
    wait_done(lat, bcnt);
    check("b2b_first_q", q, 8'h06);
    start = 1'b1; op = 2'b10; amount = 3'd2; a = 8'h80; cin = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("b2b_busy", busy, 1);
    check("b2b_load_q", q, 8'h80);
    check("b2b_load_cout", cout, 1);
    @(negedge clk);
    check("b2b_step1_q", q, 8'h40);
    check("b2b_step1_cout", cout, 0);
    @(negedge clk);
    check("b2b_done", done, 1);
    check("b2b_final_q", q, 8'h20);

`ifdef SHIFT_SEQ_ZFLAG_EN
    drive_start(2'b10, 3'd1, 8'h01, 1'b0);
    wait_done(lat, bcnt);
    check("zf_q", q, 8'h00);
    check("zf_cout", cout, 1);
    check("zf_z_set", z, 1);
    drive_start(2'b00, 3'd1, 8'h40, 1'b0);
    wait_done(lat, bcnt);
    check("zf_q2", q, 8'h80);
    check("zf_z_clear", z, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
